// File: rtl/apb_burst_scheduler_if.sv
// apb_burst_scheduler_if
// Bundles the write-path and read-path burst handshakes together with the
// APB4 master bus that the scheduler drives.
// modport master : the scheduler side
// modport slave  : the environment side (requesters, data source, APB slave)
`timescale 1ns/1ps
interface apb_burst_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    // write burst path
    logic                        wr_req_valid;
    logic                        wr_req_ready;
    logic [ADDR_WIDTH+5:0]       wr_req_desc;
    logic                        wr_dat_valid;
    logic                        wr_dat_ready;
    logic [DATA_WIDTH*9/8-1:0]   wr_dat;
    logic                        wr_rsp_valid;
    logic [1:0]                  wr_rsp;
    // read burst path
    logic                        rd_req_valid;
    logic                        rd_req_ready;
    logic [ADDR_WIDTH+5:0]       rd_req_desc;
    logic                        rd_dat_valid;
    logic [DATA_WIDTH-1:0]       rd_dat;
    logic [1:0]                  rd_rsp;
    logic                        rd_last;
    // APB4 master port
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [ADDR_WIDTH-1:0]       paddr;
    logic [DATA_WIDTH-1:0]       pwdata;
    logic [DATA_WIDTH/8-1:0]     pstrb;
    logic                        pready;
    logic [DATA_WIDTH-1:0]       prdata;
    logic                        pslverr;

    modport master (
        input  wr_req_valid, wr_req_desc, wr_dat_valid, wr_dat,
        input  rd_req_valid, rd_req_desc,
        input  pready, prdata, pslverr,
        output wr_req_ready, wr_dat_ready, wr_rsp_valid, wr_rsp,
        output rd_req_ready, rd_dat_valid, rd_dat, rd_rsp, rd_last,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output wr_req_valid, wr_req_desc, wr_dat_valid, wr_dat,
        output rd_req_valid, rd_req_desc,
        output pready, prdata, pslverr,
        input  wr_req_ready, wr_dat_ready, wr_rsp_valid, wr_rsp,
        input  rd_req_ready, rd_dat_valid, rd_dat, rd_rsp, rd_last,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_burst_scheduler.sv
// apb_burst_scheduler
// Shares one APB4 master port between an AXI write path and an AXI read path.
// Arbitrates per burst (alternating when both request), splits each burst into
// per-beat APB transfers, returns per-beat read data or one write response.
// Optional build macro: APB_TIMEOUT_EN -- an ACCESS phase that sees no pready
// for 256 cycles completes as SLVERR (read data 0) and the burst continues.
`timescale 1ns/1ps
module apb_burst_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_burst_scheduler_if.master bus
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(BYTES);

    typedef enum logic [2:0] {S_IDLE, S_WDAT, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                r_state;
    logic                  r_last_wr;     // 1: most recent grant went to the write path
    logic                  r_is_wr;
    logic                  r_err;
    logic [3:0]            r_len;
    logic [3:0]            r_beats_left;  // beats remaining after the current one
    logic [1:0]            r_burst;

    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_done;
    logic                  w_perr;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [3:0]            w_req_len;
    logic [1:0]            w_req_burst;

    // With both paths requesting, the one not served last time wins.
    assign w_grant_wr = bus.wr_req_valid && (!bus.rd_req_valid || !r_last_wr);
    assign w_grant_rd = bus.rd_req_valid && !w_grant_wr;
    assign {w_req_addr, w_req_len, w_req_burst} = w_grant_wr ? bus.wr_req_desc : bus.rd_req_desc;
    assign w_last = (r_beats_left == 4'd0);

`ifdef APB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       w_tmo;

    assign w_tmo = !bus.pready && (r_tmo_cnt == 8'hFF);

    // Counts stalled ACCESS cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state != S_ACCESS) begin
            r_tmo_cnt <= 8'd0;
        end else if (!bus.pready) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // A timed-out beat completes like a normal one but reports an error and no data.
    always_comb begin
        w_done  = bus.pready || w_tmo;
        w_perr  = bus.pslverr || w_tmo;
        w_rdata = w_tmo ? '0 : bus.prdata;
    end
`else
    // Beat completion comes only from the slave.
    always_comb begin
        w_done  = bus.pready;
        w_perr  = bus.pslverr;
        w_rdata = bus.prdata;
    end
`endif

    // Beat address advance: FIXED holds, WRAP folds into the burst-sized window,
    // everything else (INCR, reserved code, WRAP with illegal len) increments.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [3:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = addr + ADDR_WIDTH'(BYTES);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BYTE_SH) - ADDR_WIDTH'(1);
        if (burst == 2'b00)
            next_addr = addr;
        else if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            next_addr = (addr & ~mask) | (incr & mask);
        else
            next_addr = incr;
    endfunction

    // Burst FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_last_wr        <= 1'b0;
            r_is_wr          <= 1'b0;
            r_err            <= 1'b0;
            r_len            <= 4'd0;
            r_beats_left     <= 4'd0;
            r_burst          <= 2'b00;
            bus.wr_req_ready <= 1'b0;
            bus.wr_dat_ready <= 1'b0;
            bus.wr_rsp_valid <= 1'b0;
            bus.wr_rsp       <= 2'b00;
            bus.rd_req_ready <= 1'b0;
            bus.rd_dat_valid <= 1'b0;
            bus.rd_dat       <= '0;
            bus.rd_rsp       <= 2'b00;
            bus.rd_last      <= 1'b0;
            bus.psel         <= 1'b0;
            bus.penable      <= 1'b0;
            bus.pwrite       <= 1'b0;
            bus.paddr        <= '0;
            bus.pwdata       <= '0;
            bus.pstrb        <= '0;
        end else begin
            // single-cycle pulses
            bus.wr_req_ready <= 1'b0;
            bus.rd_req_ready <= 1'b0;
            bus.rd_dat_valid <= 1'b0;
            bus.rd_last      <= 1'b0;
            bus.wr_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (w_grant_wr || w_grant_rd) begin
                        r_is_wr      <= w_grant_wr;
                        r_last_wr    <= w_grant_wr;
                        r_len        <= w_req_len;
                        r_burst      <= w_req_burst;
                        r_beats_left <= w_req_len;
                        bus.paddr    <= w_req_addr;
                        bus.pwrite   <= w_grant_wr;
                        if (w_grant_wr) begin
                            bus.wr_req_ready <= 1'b1;
                            bus.wr_dat_ready <= 1'b1;
                            r_state          <= S_WDAT;
                        end else begin
                            bus.rd_req_ready <= 1'b1;
                            bus.pwdata       <= '0;
                            bus.pstrb        <= '0;
                            bus.psel         <= 1'b1;
                            r_state          <= S_SETUP;
                        end
                    end
                end
                S_WDAT: begin
                    if (bus.wr_dat_valid) begin
                        bus.pwdata       <= bus.wr_dat[DATA_WIDTH-1:0];
                        bus.pstrb        <= bus.wr_dat[DATA_WIDTH +: BYTES];
                        bus.wr_dat_ready <= 1'b0;
                        bus.psel         <= 1'b1;
                        r_state          <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bus.penable <= 1'b1;
                    r_state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        bus.penable  <= 1'b0;
                        bus.paddr    <= next_addr(bus.paddr, r_len, r_burst);
                        r_beats_left <= r_beats_left - 4'd1;
                        if (r_is_wr) begin
                            // writes leave the bus idle while the next beat is fetched
                            bus.psel <= 1'b0;
                            r_err    <= r_err | w_perr;
                            if (w_last) begin
                                bus.wr_rsp_valid <= 1'b1;
                                bus.wr_rsp       <= (r_err || w_perr) ? 2'b10 : 2'b00;
                                r_state          <= S_RESP;
                            end else begin
                                bus.wr_dat_ready <= 1'b1;
                                r_state          <= S_WDAT;
                            end
                        end else begin
                            bus.rd_dat_valid <= 1'b1;
                            bus.rd_dat       <= w_rdata;
                            bus.rd_rsp       <= {w_perr, 1'b0};
                            bus.rd_last      <= w_last;
                            // read beats chain ACCESS -> SETUP; penable always drops
                            if (w_last) begin
                                bus.psel <= 1'b0;
                                r_state  <= S_IDLE;
                            end else begin
                                r_state  <= S_SETUP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_burst_scheduler.sv
// tb_apb_burst_scheduler
// Directed bench for apb_burst_scheduler: reset values, arbitration order,
// INCR/WRAP/FIXED address sequences, error reporting, wait-state stability
// and asynchronous reset in the middle of an ACCESS phase.
`timescale 1ns/1ps
module tb_apb_burst_scheduler;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_burst_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    apb_burst_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_checks;
    int n_errors;

    // write beat source and per-burst records
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    logic [31:0] ea [4];
    logic [31:0] r_addr [$];
    logic [31:0] r_wd [$];
    logic [3:0]  r_st [$];
    logic        r_pw [$];
    logic [31:0] r_rd [$];
    logic [1:0]  r_rr [$];
    logic        r_rl [$];
    int          n_rsp, rdy_cycles, rdy_cyc, psel_cyc, n_setup;
    logic [1:0]  last_rsp;
    bit          done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b);
        return {a, l, b};
    endfunction

    // Drives one burst to completion, acting as requester, data source and APB slave
    // (pready=1, prdata=D000_0000+beat, pslverr on beat err_beat).
    task automatic run_burst(input bit is_wr, input logic [37:0] desc, input int nbeats,
                             input int err_beat, input int budget);
        int  cyc, nacc, nwr;
        bit  hs, wacc, pdone;
        r_addr.delete(); r_wd.delete(); r_st.delete(); r_pw.delete();
        r_rd.delete(); r_rr.delete(); r_rl.delete();
        n_rsp = 0; rdy_cycles = 0; rdy_cyc = -1; psel_cyc = -1; n_setup = 0;
        last_rsp = 2'b00; done = 0; cyc = 0; nacc = 0; nwr = 0;
        bif.pready = 1'b1;
        if (is_wr) begin bif.wr_req_desc = desc; bif.wr_req_valid = 1'b1; end
        else       begin bif.rd_req_desc = desc; bif.rd_req_valid = 1'b1; end
        while (!done && cyc < budget) begin
            bif.pslverr      = (nacc == err_beat);
            bif.prdata       = 32'hD000_0000 + 32'(nacc);
            bif.wr_dat_valid = is_wr && (nwr < nbeats);
            bif.wr_dat       = {ws[nwr % 4], wd[nwr % 4]};
            hs    = is_wr ? (bif.wr_req_valid && bif.wr_req_ready) : (bif.rd_req_valid && bif.rd_req_ready);
            wacc  = bif.wr_dat_valid && bif.wr_dat_ready;
            pdone = bif.psel && bif.penable && bif.pready;
            if (pdone) begin
                r_addr.push_back(bif.paddr); r_wd.push_back(bif.pwdata);
                r_st.push_back(bif.pstrb);   r_pw.push_back(bif.pwrite);
            end
            tick();
            cyc++;
            if (hs) begin bif.wr_req_valid = 1'b0; bif.rd_req_valid = 1'b0; end
            if (wacc) nwr++;
            if (pdone) nacc++;
            if (bif.wr_req_ready || bif.rd_req_ready) begin
                rdy_cycles++;
                if (rdy_cyc < 0) rdy_cyc = cyc;
            end
            if (bif.psel && !bif.penable) begin
                n_setup++;
                if (psel_cyc < 0) psel_cyc = cyc;
            end
            if (bif.wr_rsp_valid) begin
                n_rsp++; last_rsp = bif.wr_rsp;
                if (is_wr) done = 1;
            end
            if (bif.rd_dat_valid) begin
                r_rd.push_back(bif.rd_dat); r_rr.push_back(bif.rd_rsp); r_rl.push_back(bif.rd_last);
                if (bif.rd_last) done = 1;
            end
        end
        bif.wr_req_valid = 1'b0; bif.rd_req_valid = 1'b0;
        bif.wr_dat_valid = 1'b0; bif.pslverr = 1'b0;
        chk("burst_completed", 64'(done), 64'd1);
        tick();
        chk("rsp_pulse_one_cycle", 64'({bif.wr_rsp_valid, bif.rd_dat_valid}), 64'd0);
    endtask

    task automatic chk_addrs(input string tag, input int n);
        chk({tag, "_nbeats"}, 64'(r_addr.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_paddr%0d", tag, i), 64'(r_addr[i]), 64'(ea[i]));
    endtask

    int   ng, dup, both, nw, nr, cyc;
    logic [3:0] grants;
    bit   prev_w, prev_r;

    initial begin
        n_checks = 0; n_errors = 0;
        bif.wr_req_valid = 1'b0; bif.wr_req_desc = '0;
        bif.wr_dat_valid = 1'b0; bif.wr_dat = '0;
        bif.rd_req_valid = 1'b0; bif.rd_req_desc = '0;
        bif.pready = 1'b0; bif.prdata = '0; bif.pslverr = 1'b0;
        repeat (3) tick();

        // ---------------- reset state
        chk("rst_psel",         64'(bif.psel),         64'd0);
        chk("rst_penable",      64'(bif.penable),      64'd0);
        chk("rst_wr_req_ready", 64'(bif.wr_req_ready), 64'd0);
        chk("rst_rd_req_ready", 64'(bif.rd_req_ready), 64'd0);
        chk("rst_wr_dat_ready", 64'(bif.wr_dat_ready), 64'd0);
        chk("rst_wr_rsp_valid", 64'(bif.wr_rsp_valid), 64'd0);
        chk("rst_rd_dat_valid", 64'(bif.rd_dat_valid), 64'd0);
        chk("rst_paddr",        64'(bif.paddr),        64'd0);
        chk("rst_pstrb",        64'(bif.pstrb),        64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- arbitration: both requesting for two rounds -> W,R,W,R
        bif.wr_req_desc = mk(32'h3000, 4'd0, 2'b01);
        bif.rd_req_desc = mk(32'h3100, 4'd0, 2'b01);
        bif.wr_dat = {4'hF, 32'h1234_5678}; bif.wr_dat_valid = 1'b1;
        bif.pready = 1'b1;
        bif.wr_req_valid = 1'b1; bif.rd_req_valid = 1'b1;
        ng = 0; dup = 0; both = 0; nw = 0; nr = 0; cyc = 0; grants = 4'b0000;
        prev_w = 0; prev_r = 0;
        while ((ng < 4 || nw < 2 || nr < 2) && cyc < 80) begin
            if (ng == 4 && !bif.wr_req_ready && !bif.rd_req_ready) begin
                bif.wr_req_valid = 1'b0; bif.rd_req_valid = 1'b0;
            end
            tick();
            cyc++;
            if (bif.wr_req_ready && prev_w) dup++;
            if (bif.rd_req_ready && prev_r) dup++;
            if (bif.wr_req_ready && bif.rd_req_ready) both++;
            if (bif.wr_req_ready && !prev_w && ng < 4) begin grants[3-ng] = 1'b1; ng++; end
            if (bif.rd_req_ready && !prev_r && ng < 4) begin grants[3-ng] = 1'b0; ng++; end
            prev_w = bif.wr_req_ready; prev_r = bif.rd_req_ready;
            if (bif.wr_rsp_valid) nw++;
            if (bif.rd_dat_valid) nr++;
        end
        bif.wr_req_valid = 1'b0; bif.rd_req_valid = 1'b0; bif.wr_dat_valid = 1'b0;
        chk("arb_ngrants",      64'(ng),     64'd4);
        chk("arb_order_WRWR",   64'(grants), 64'b1010);
        chk("arb_ready_1cycle", 64'(dup),    64'd0);
        chk("arb_ready_excl",   64'(both),   64'd0);
        chk("arb_wr_rsps",      64'(nw),     64'd2);
        chk("arb_rd_beats",     64'(nr),     64'd2);
        repeat (3) tick();

        // ---------------- write INCR len=3 @0x1000
        wd = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        ws = '{4'hF, 4'h3, 4'hC, 4'h8};
        run_burst(1'b1, mk(32'h1000, 4'd3, 2'b01), 4, -1, 60);
        ea = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        chk_addrs("wincr", 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wincr_pwdata%0d", i), 64'(r_wd[i]), 64'(wd[i]));
            chk($sformatf("wincr_pstrb%0d", i),  64'(r_st[i]), 64'(ws[i]));
            chk($sformatf("wincr_pwrite%0d", i), 64'(r_pw[i]), 64'd1);
        end
        chk("wincr_nrsp",       64'(n_rsp),      64'd1);
        chk("wincr_rsp_okay",   64'(last_rsp),   64'd0);
        chk("wincr_ready_cyc",  64'(rdy_cycles), 64'd1);
        chk("wincr_grant_at",   64'(rdy_cyc),    64'd1);
        chk("wincr_psel_at",    64'(psel_cyc),   64'd2);
        chk("wincr_setups",     64'(n_setup),    64'd4);

        // ---------------- read WRAP len=3 @0x108
        run_burst(1'b0, mk(32'h108, 4'd3, 2'b10), 4, -1, 60);
        ea = '{32'h108, 32'h10C, 32'h100, 32'h104};
        chk_addrs("rwrap", 4);
        chk("rwrap_nbeats_out", 64'(r_rd.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rwrap_rd_dat%0d", i), 64'(r_rd[i]), 64'(32'hD000_0000 + 32'(i)));
            chk($sformatf("rwrap_rd_rsp%0d", i), 64'(r_rr[i]), 64'd0);
            chk($sformatf("rwrap_rd_last%0d", i), 64'(r_rl[i]), 64'(i == 3));
            chk($sformatf("rwrap_pstrb%0d", i), 64'(r_st[i]), 64'd0);
            chk($sformatf("rwrap_pwrite%0d", i), 64'(r_pw[i]), 64'd0);
        end
        chk("rwrap_grant_at", 64'(rdy_cyc),  64'd1);
        chk("rwrap_psel_at",  64'(psel_cyc), 64'd1);
        chk("rwrap_setups",   64'(n_setup),  64'd4);
        chk("rwrap_no_wrsp",  64'(n_rsp),    64'd0);

        // ---------------- write INCR len=3 with SLVERR on beat 2
        run_burst(1'b1, mk(32'h1100, 4'd3, 2'b01), 4, 1, 60);
        ea = '{32'h1100, 32'h1104, 32'h1108, 32'h110C};
        chk_addrs("werr", 4);
        chk("werr_nrsp",   64'(n_rsp),    64'd1);
        chk("werr_slverr", 64'(last_rsp), 64'b10);

        // ---------------- read INCR len=3 with SLVERR on beat 3
        run_burst(1'b0, mk(32'h200, 4'd3, 2'b01), 4, 2, 60);
        ea = '{32'h200, 32'h204, 32'h208, 32'h20C};
        chk_addrs("rerr", 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rerr_rd_rsp%0d", i), 64'(r_rr[i]), (i == 2) ? 64'b10 : 64'b00);
        chk("rerr_rd_dat2", 64'(r_rd[2]), 64'h0000_0000_D000_0002);

        // ---------------- read FIXED len=1 @0x300
        run_burst(1'b0, mk(32'h300, 4'd1, 2'b00), 2, -1, 40);
        ea = '{32'h300, 32'h300, 32'h0, 32'h0};
        chk_addrs("rfixed", 2);
        chk("rfixed_last0", 64'(r_rl[0]), 64'd0);
        chk("rfixed_last1", 64'(r_rl[1]), 64'd1);

        // ---------------- read WRAP with len=2 behaves as INCR
        run_burst(1'b0, mk(32'h10C, 4'd2, 2'b10), 3, -1, 40);
        ea = '{32'h10C, 32'h110, 32'h114, 32'h0};
        chk_addrs("rwrap_len2", 3);

        // ---------------- read INCR crossing the top of the address space
        run_burst(1'b0, mk(32'hFFFF_FFFC, 4'd1, 2'b01), 2, -1, 40);
        ea = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
        chk_addrs("rincr_top", 2);

        // ---------------- write WRAP len=1 @0x204 (8-byte window)
        wd = '{32'hB000_0000, 32'hB000_0001, 32'h0, 32'h0};
        ws = '{4'h1, 4'h2, 4'h0, 4'h0};
        run_burst(1'b1, mk(32'h204, 4'd1, 2'b10), 2, -1, 40);
        ea = '{32'h204, 32'h200, 32'h0, 32'h0};
        chk_addrs("wwrap", 2);
        chk("wwrap_pwdata1", 64'(r_wd[1]), 64'h0000_0000_B000_0001);
        chk("wwrap_rsp",     64'(last_rsp), 64'd0);

        // ---------------- wait states: pready low for 5 ACCESS edges
        bif.pready = 1'b0;
        bif.wr_req_desc = mk(32'h2000, 4'd0, 2'b01);
        bif.wr_dat = {4'h5, 32'hCAFE_F00D};
        bif.wr_req_valid = 1'b1; bif.wr_dat_valid = 1'b1;
        tick();
        chk("stall_wr_req_ready", 64'(bif.wr_req_ready), 64'd1);
        bif.wr_req_valid = 1'b0;
        tick();
        chk("stall_setup", 64'({bif.psel, bif.penable}), 64'b10);
        bif.wr_dat_valid = 1'b0;
        tick();
        chk("stall_access", 64'({bif.psel, bif.penable}), 64'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_paddr%0d", i),   64'(bif.paddr),   64'h2000);
            chk($sformatf("stall_pwdata%0d", i),  64'(bif.pwdata),  64'h0000_0000_CAFE_F00D);
            chk($sformatf("stall_pstrb%0d", i),   64'(bif.pstrb),   64'h5);
            chk($sformatf("stall_penable%0d", i), 64'({bif.psel, bif.penable}), 64'b11);
        end
        bif.pready = 1'b1;
        tick();
        chk("stall_rsp_valid", 64'(bif.wr_rsp_valid), 64'd1);
        chk("stall_rsp",       64'(bif.wr_rsp),       64'd0);
        chk("stall_psel_drop", 64'(bif.psel),         64'd0);
        tick();
        chk("stall_rsp_pulse", 64'(bif.wr_rsp_valid), 64'd0);

        // ---------------- asynchronous reset in the middle of ACCESS
        bif.pready = 1'b0;
        bif.rd_req_desc = mk(32'h400, 4'd0, 2'b01);
        bif.rd_req_valid = 1'b1;
        tick();
        chk("arst_rd_req_ready", 64'(bif.rd_req_ready), 64'd1);
        bif.rd_req_valid = 1'b0;
        tick();
        chk("arst_in_access", 64'({bif.psel, bif.penable}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_psel_now", 64'({bif.psel, bif.penable}), 64'b00);
        bif.pready = 1'b1; bif.prdata = 32'hFFFF_FFFF;
        nw = 0; nr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bif.wr_rsp_valid) nw++;
            if (bif.rd_dat_valid) nr++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bif.wr_rsp_valid) nw++;
            if (bif.rd_dat_valid) nr++;
        end
        chk("arst_no_rd_pulse", 64'(nr), 64'd0);
        chk("arst_no_wr_pulse", 64'(nw), 64'd0);
        chk("arst_idle_psel",   64'(bif.psel), 64'd0);

        // after reset the write path wins a simultaneous request
        bif.wr_req_desc = mk(32'h500, 4'd0, 2'b01);
        bif.rd_req_desc = mk(32'h600, 4'd0, 2'b01);
        bif.wr_req_valid = 1'b1; bif.rd_req_valid = 1'b1;
        tick();
        chk("arst_first_grant_wr", 64'(bif.wr_req_ready), 64'd1);
        chk("arst_first_grant_rd", 64'(bif.rd_req_ready), 64'd0);
        bif.wr_req_valid = 1'b0; bif.rd_req_valid = 1'b0;
        bif.wr_dat = {4'hF, 32'h5555_AAAA}; bif.wr_dat_valid = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bif.wr_dat_ready == 1'b0) bif.wr_dat_valid = 1'b0;
            if (bif.wr_rsp_valid) nw++;
            if (bif.rd_dat_valid) nr++;
        end
        chk("post_rst_wr_rsp", 64'(nw), 64'd1);
        chk("post_rst_no_rd",  64'(nr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
